// File: rtl/four_digit_capture_if.sv
// Multiplexed seven-segment capture bus: the display-side inputs and the decoded per-digit results.
interface four_digit_capture_if;
  logic [7:0] segments;
  logic [3:0] digit_select;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic [3:0] dp;
  logic [3:0] digit_valid;
  logic       frame_done;
  logic       pattern_err;

  modport master (
    output segments, digit_select,
    input  digit0, digit1, digit2, digit3, dp, digit_valid, frame_done, pattern_err
  );

  modport slave (
    input  segments, digit_select,
    output digit0, digit1, digit2, digit3, dp, digit_valid, frame_done, pattern_err
  );
endinterface

// File: rtl/four_digit_capture.sv
// Captures a 4-digit multiplexed active-low seven-segment display into hex digits.
// Optional decimal-point capture is built only when FOUR_DIGIT_CAPTURE_DP_EN is defined.
module four_digit_capture #(
  parameter int STABLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic             clk,
  input logic             rst,
  four_digit_capture_if.slave bus
);

`ifdef FOUR_DIGIT_CAPTURE_DP_EN
  localparam int SEG_W = 8;
`else
  localparam int SEG_W = 7;
`endif

  typedef enum logic [1:0] {IDLE, TRACK, HELD} state_t;

  state_t             state, state_nx;
  logic [SEG_W-1:0]   seg_p0, prev_seg;
  logic [3:0]         sel_p0, prev_sel;
  logic [3:0]         cnt, cnt_nx;
  logic               onehot, capture, dec_ok, tmo_hit;
  logic [3:0]         dec_val;
  logic [1:0]         idx, exp_idx;
  logic [15:0]        tmo_cnt, tmo_nx;
  logic [3:0]         dig_q [4];
  logic [3:0]         valid_q;
  logic               frame_q, err_q;

  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h40: decode = {1'b1, 4'h0};
      7'h79: decode = {1'b1, 4'h1};
      7'h24: decode = {1'b1, 4'h2};
      7'h30: decode = {1'b1, 4'h3};
      7'h19: decode = {1'b1, 4'h4};
      7'h12: decode = {1'b1, 4'h5};
      7'h02: decode = {1'b1, 4'h6};
      7'h78: decode = {1'b1, 4'h7};
      7'h00: decode = {1'b1, 4'h8};
      7'h18: decode = {1'b1, 4'h9};
      7'h08: decode = {1'b1, 4'hA};
      7'h03: decode = {1'b1, 4'hB};
      7'h46: decode = {1'b1, 4'hC};
      7'h21: decode = {1'b1, 4'hD};
      7'h06: decode = {1'b1, 4'hE};
      7'h0E: decode = {1'b1, 4'hF};
      default: decode = {1'b0, 4'h0};
    endcase
  endfunction

  function automatic logic [1:0] sel_idx(input logic [3:0] s);
    case (s)
      4'b1101: sel_idx = 2'd1;
      4'b1011: sel_idx = 2'd2;
      4'b0111: sel_idx = 2'd3;
      default: sel_idx = 2'd0;
    endcase
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    sat_inc = (v == 16'(TIMEOUT_CYCLES)) ? v : v + 16'd1;
  endfunction

  always_comb begin
    onehot   = (sel_p0 == 4'b1110) || (sel_p0 == 4'b1101) ||
               (sel_p0 == 4'b1011) || (sel_p0 == 4'b0111);
    {dec_ok, dec_val} = decode(seg_p0[6:0]);
    idx      = sel_idx(sel_p0);
    state_nx = state;
    cnt_nx   = cnt;
    capture  = 1'b0;
    case (state)
      IDLE: begin
        if (onehot) begin
          state_nx = TRACK;
          cnt_nx   = 4'd1;
        end
      end
      TRACK: begin
        if (!onehot) begin
          state_nx = IDLE;
          cnt_nx   = 4'd0;
        end else if (seg_p0 == prev_seg && sel_p0 == prev_sel) begin
          cnt_nx = cnt + 4'd1;
        end else begin
          cnt_nx = 4'd1;
        end
      end
      HELD: begin
        // Segment changes are ignored while held; only a new select re-arms tracking.
        if (sel_p0 != prev_sel) begin
          state_nx = onehot ? TRACK : IDLE;
          cnt_nx   = onehot ? 4'd1 : 4'd0;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 4'd0;
      end
    endcase
    if (state_nx == TRACK && cnt_nx == 4'(STABLE_CYCLES)) begin
      capture  = 1'b1;
      state_nx = HELD;
    end
    tmo_nx  = (capture && dec_ok) ? 16'd0 : sat_inc(tmo_cnt);
    tmo_hit = !(capture && dec_ok) && (tmo_nx == 16'(TIMEOUT_CYCLES));
  end

  // Stage p0: input register; everything downstream works on seg_p0/sel_p0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_p0   <= '1;
      sel_p0   <= 4'hF;
      prev_seg <= '1;
      prev_sel <= 4'hF;
      state    <= IDLE;
      cnt      <= 4'd0;
      tmo_cnt  <= 16'd0;
      exp_idx  <= 2'd0;
      valid_q  <= 4'b0000;
      frame_q  <= 1'b0;
      err_q    <= 1'b0;
      for (int i = 0; i < 4; i++) dig_q[i] <= 4'h0;
    end else begin
      seg_p0   <= bus.segments[SEG_W-1:0];
      sel_p0   <= bus.digit_select;
      prev_seg <= seg_p0;
      prev_sel <= sel_p0;
      state    <= state_nx;
      cnt      <= cnt_nx;
      tmo_cnt  <= tmo_nx;
      frame_q  <= 1'b0;
      err_q    <= 1'b0;
      if (tmo_hit) begin
        valid_q <= 4'b0000;
        exp_idx <= 2'd0;
      end
      // A capture overrides the timeout clear for its own digit and the tracker.
      if (capture) begin
        if (dec_ok) begin
          dig_q[idx]   <= dec_val;
          valid_q[idx] <= 1'b1;
          if (idx == exp_idx) begin
            if (idx == 2'd3) begin
              frame_q <= 1'b1;
              exp_idx <= 2'd0;
            end else begin
              exp_idx <= exp_idx + 2'd1;
            end
          end else begin
            exp_idx <= (idx == 2'd0) ? 2'd1 : 2'd0;
          end
        end else begin
          err_q        <= 1'b1;
          valid_q[idx] <= 1'b0;
          exp_idx      <= 2'd0;
        end
      end
    end
  end

`ifdef FOUR_DIGIT_CAPTURE_DP_EN
  logic [3:0] dp_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_q <= 4'b0000;
    end else if (capture && dec_ok) begin
      dp_q[idx] <= ~seg_p0[7];
    end
  end

  assign bus.dp = dp_q;
`else
  assign bus.dp = 4'b0000;
`endif

  assign bus.digit0      = dig_q[0];
  assign bus.digit1      = dig_q[1];
  assign bus.digit2      = dig_q[2];
  assign bus.digit3      = dig_q[3];
  assign bus.digit_valid = valid_q;
  assign bus.frame_done  = frame_q;
  assign bus.pattern_err = err_q;

endmodule

// File: tb/tb_four_digit_capture.sv
// Scoreboard bench for four_digit_capture: stimulus queues expected output events, a monitor checks them.
module tb_four_digit_capture;
  localparam int TMO = 64;

`ifdef FOUR_DIGIT_CAPTURE_DP_EN
  localparam logic [3:0] DP0 = 4'b0001;
`else
  localparam logic [3:0] DP0 = 4'b0000;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [25:0] exp_q[$];
  string       name_q[$];
  logic [23:0] last_snap, now_snap;
  logic [25:0] got_ev, want_ev;
  string       ev_name;

  always #5 clk = ~clk;

  four_digit_capture_if bus();

  four_digit_capture #(
    .STABLE_CYCLES (2),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  function automatic logic [23:0] snap();
    return {bus.digit3, bus.digit2, bus.digit1, bus.digit0, bus.dp, bus.digit_valid};
  endfunction

  task automatic push(input string nm, input logic [3:0] d3, input logic [3:0] d2,
                      input logic [3:0] d1, input logic [3:0] d0, input logic [3:0] dpv,
                      input logic [3:0] v, input logic fd, input logic pe);
    exp_q.push_back({d3, d2, d1, d0, dpv, v, fd, pe});
    name_q.push_back(nm);
  endtask

  task automatic drive(input logic [3:0] s, input logic [7:0] g, input int n);
    bus.digit_select = s;
    bus.segments     = g;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string nm);
    n_cmp++;
    if ({snap(), bus.frame_done, bus.pattern_err} !== 26'd0) begin
      n_bad++;
      $display("FAIL %s: got %h want 0000000", nm, {snap(), bus.frame_done, bus.pattern_err});
    end
  endtask

  // Monitor: any change of the held outputs or any pulse is one observed event
  initial begin : monitor
    last_snap = '0;
    forever begin
      @(negedge clk);
      now_snap = snap();
      if (rst) begin
        last_snap = now_snap;
      end else if (now_snap != last_snap || bus.frame_done || bus.pattern_err) begin
        got_ev = {now_snap, bus.frame_done, bus.pattern_err};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_event: got %h want no event", got_ev);
        end else begin
          want_ev = exp_q.pop_front();
          ev_name = name_q.pop_front();
          if (got_ev !== want_ev) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", ev_name, got_ev, want_ev);
          end
        end
        last_snap = now_snap;
      end
    end
  end

  initial begin : stimulus
    bus.digit_select = 4'hF;
    bus.segments     = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset_state");
    rst = 1'b0;
    drive(4'hF, 8'hFF, 2);

    // Full frame 0,2,4,F
    push("frame_d0", 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 4'b0001, 1'b0, 1'b0);
    drive(4'b1110, 8'hC0, 4);
    push("frame_d1", 4'h0, 4'h0, 4'h2, 4'h0, 4'b0000, 4'b0011, 1'b0, 1'b0);
    drive(4'b1101, 8'hA4, 4);
    push("frame_d2", 4'h0, 4'h4, 4'h2, 4'h0, 4'b0000, 4'b0111, 1'b0, 1'b0);
    drive(4'b1011, 8'h99, 4);
    push("frame_d3", 4'hF, 4'h4, 4'h2, 4'h0, 4'b0000, 4'b1111, 1'b1, 1'b0);
    drive(4'b0111, 8'h8E, 4);
    drive(4'hF, 8'hFF, 2);

    // Undecodable pattern on digit1
    push("bad_pattern", 4'hF, 4'h4, 4'h2, 4'h0, 4'b0000, 4'b1101, 1'b0, 1'b1);
    drive(4'b1101, 8'hFF, 4);
    drive(4'hF, 8'hFF, 2);

    // Unstable segments never capture; two stable samples do
    for (int i = 0; i < 6; i++) drive(4'b1110, (i % 2 == 1) ? 8'hA4 : 8'hF9, 1);
    push("stable_d0", 4'hF, 4'h4, 4'h2, 4'h1, 4'b0000, 4'b1101, 1'b0, 1'b0);
    drive(4'b1110, 8'hF9, 2);
    drive(4'hF, 8'hFF, 2);

    // Out-of-order 0,2,1,3 then in-order 0,1,2,3
    push("ooo_d0", 4'hF, 4'h4, 4'h2, 4'h0, 4'b0000, 4'b1101, 1'b0, 1'b0);
    drive(4'b1110, 8'hC0, 4);
    push("ooo_d2", 4'hF, 4'h2, 4'h2, 4'h0, 4'b0000, 4'b1101, 1'b0, 1'b0);
    drive(4'b1011, 8'hA4, 4);
    push("ooo_d1", 4'hF, 4'h2, 4'h4, 4'h0, 4'b0000, 4'b1111, 1'b0, 1'b0);
    drive(4'b1101, 8'h99, 4);
    push("ooo_d3", 4'h1, 4'h2, 4'h4, 4'h0, 4'b0000, 4'b1111, 1'b0, 1'b0);
    drive(4'b0111, 8'hF9, 4);
    push("seq_d0", 4'h1, 4'h2, 4'h4, 4'h1, 4'b0000, 4'b1111, 1'b0, 1'b0);
    drive(4'b1110, 8'hF9, 4);
    push("seq_d1", 4'h1, 4'h2, 4'h2, 4'h1, 4'b0000, 4'b1111, 1'b0, 1'b0);
    drive(4'b1101, 8'hA4, 4);
    push("seq_d2", 4'h1, 4'h4, 4'h2, 4'h1, 4'b0000, 4'b1111, 1'b0, 1'b0);
    drive(4'b1011, 8'h99, 4);
    push("seq_d3", 4'hF, 4'h4, 4'h2, 4'h1, 4'b0000, 4'b1111, 1'b1, 1'b0);
    drive(4'b0111, 8'h8E, 4);

    // Timeout clears valid flags but keeps digit values
    push("timeout", 4'hF, 4'h4, 4'h2, 4'h1, 4'b0000, 4'b0000, 1'b0, 1'b0);
    drive(4'hF, 8'hFF, TMO + 16);
    push("dp_d0", 4'hF, 4'h4, 4'h2, 4'h0, DP0, 4'b0001, 1'b0, 1'b0);
    drive(4'b1110, 8'h40, 4);

    // Reset in the middle of tracking digit2
    drive(4'b1011, 8'h99, 2);
    rst = 1'b1;
    #1;
    check_reset("reset_mid_track");
    drive(4'hF, 8'hFF, 3);
    rst = 1'b0;
    drive(4'hF, 8'hFF, 10);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL missing_events: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/four_digit_capture.md
FOUR_DIGIT_CAPTURE -- requirements
Module: four_digit_capture

Interface
REQ-001 Parameter STABLE_CYCLES, default 2, meaning: the number of consecutive identical input samples required before a digit is accepted (legal range 1..15).
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, meaning: the number of cycles without an accepted digit after which all valid flags clear (legal range 16..65535).
REQ-003 clk  input  1  Sole clock; all logic SHALL be clocked on its rising edge.
REQ-004 rst  input  1  Asynchronous, active-high reset.
REQ-005 segments  input  8  Multiplexed segment bus {dp,g,f,e,d,c,b,a}, active-low (0 = lit).
REQ-006 digit_select  input  4  Active-low digit enable; bit0 = digit0 (LSB) through bit3 = digit3 (MSB).
REQ-007 digit0..digit3  output  4 each  Last accepted hex value per digit.
REQ-008 dp  output  4  Last accepted decimal point per digit; 1 = lit.
REQ-009 digit_valid  output  4  Per-digit flag: the digit holds a successfully decoded value.
REQ-010 frame_done  output  1  One-cycle pulse when digits 0,1,2,3 have been accepted in that order.
REQ-011 pattern_err  output  1  One-cycle pulse when a stable pattern fails to decode.

Function
REQ-012 The block SHALL register segments and digit_select once before any use; all latencies below are counted from that register.
REQ-013 The FSM SHALL have three states: IDLE, TRACK and HELD.
REQ-014 IDLE -> TRACK: when the registered digit_select is exactly one-hot-low (1110, 1101, 1011 or 0111); the stability counter loads 1.
REQ-015 TRACK: while segments and digit_select equal the previous sample, the counter SHALL increment; any change SHALL reload the counter to 1 and stay in TRACK, or go to IDLE if the select is no longer one-hot-low.
REQ-016 TRACK -> HELD: when the counter reaches STABLE_CYCLES, the pattern is decoded in the same cycle and outputs update on the next edge.
REQ-017 HELD: the block SHALL stay in HELD until digit_select changes, then re-evaluate as from IDLE in that same cycle.
REQ-018 Decode SHALL use segments[6:0] only, with the codes 0x40,79,24,30,19,12,02,78,00,18,08,03,46,21,06,0E mapping to hex 0..F.
REQ-019 On a successful decode: update the digit value, set dp[n] = ~segments[7], set digit_valid[n], and restart the timeout counter.
REQ-020 On a failed decode: pulse pattern_err, clear digit_valid[n], and leave the digit value unchanged.
REQ-021 A sequence tracker SHALL expect digit0 first, then 1, 2, 3; each successful decode of the expected digit advances it.
REQ-022 A successful decode of digit3 when expected SHALL pulse frame_done in the same cycle as the output update, and the tracker SHALL return to expecting digit0.
REQ-023 An out-of-order acceptance or a failed decode SHALL reset the tracker; if the offending digit is digit0 and it decoded successfully, the tracker SHALL then expect digit1.
REQ-024 When the timeout counter reaches TIMEOUT_CYCLES: digit_valid SHALL clear to 0000, the tracker SHALL reset, and the counter SHALL saturate until the next successful decode.
REQ-025 digit_select = 1111, or any pattern that is not one-hot-low, SHALL force IDLE with no capture.
REQ-026 A successful decode coinciding with a timeout SHALL take priority and set its valid bit.

Reset
REQ-027 While rst is high: digit0..3 = 0, dp = 0000, digit_valid = 0000, frame_done = 0, pattern_err = 0, FSM = IDLE, tracker expects digit0, all counters = 0, input registers = segments 8'hFF and select 4'hF.
REQ-028 Reset asserted mid-TRACK or mid-HELD SHALL abort the capture with no output pulse.

Configuration
REQ-029 Macro FOUR_DIGIT_CAPTURE_DP_EN: when defined, dp SHALL behave as in REQ-019; when undefined, dp SHALL be constant 0000, segments[7] SHALL be ignored, and no dp registers are built.

Verification
REQ-030 Drive select 1110/1101/1011/0111 with codes C0, A4, 99, 8E, each held 4 cycles -> digits = 0,2,4,F, digit_valid = 1111, exactly one frame_done pulse.
REQ-031 Select 1101 with segments 0xFF held 4 cycles -> one pattern_err pulse, digit_valid[1] = 0, digit1 unchanged.
REQ-032 Segments alternating between F9 and A4 every cycle under select 1110 (STABLE_CYCLES = 2) -> no capture; then hold F9 for 2 cycles -> digit0 = 1.
REQ-033 Capture digits in the order 0,2,1,3 -> no frame_done; a following correct 0,1,2,3 sequence -> one frame_done.
REQ-034 Select held at 1111 for TIMEOUT_CYCLES after a full frame -> digit_valid = 0000 and digit values retained; then drive 0x40 (dp lit) on digit0 with the macro defined -> dp[0] = 1, digit_valid = 0001.
REQ-035 Assert rst during TRACK on digit2 -> all outputs take their reset values immediately and no pulses occur.
